// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot-time instruction memory loader from a byte-serial host stream
module imem_boot_loader #(
  parameter int          IMEM_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_load,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        loader_done,
  output logic        load_error,
  output logic        core_rst_n,
  output logic [15:0] words_loaded
);

  localparam int WIW = $clog2(IMEM_WORDS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]     byte_idx;
  logic [23:0]    asm_q;
  logic [WIW-1:0] word_idx;
  logic [WIW-1:0] len_q;
  logic [31:0]    sum_q;
  logic [31:0]    idle_cnt;
  logic           imem_we_q;
  logic [31:0]    imem_wdata_q;

  logic           active;
  logic           hs;
  logic           last_byte;
  logic           start_ok;
  logic           timeout_hit;
  logic [31:0]    full_word;

  // The byte currently on the bus completes a word when it is the fourth one.
  assign active      = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign hs          = byte_valid && active;
  assign last_byte   = hs && (byte_idx == 2'd3);
  assign full_word   = {byte_data, asm_q};
  assign start_ok    = start_load && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && active && !hs &&
                       (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  assign imem_we    = imem_we_q;
  assign imem_wdata = imem_wdata_q;
  assign imem_waddr = BASE_ADDR + (32'(word_idx) << 2);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decisions; length and checksum are judged on the completing byte itself.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_load) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (last_byte) begin
          if (full_word > 32'(IMEM_WORDS)) state_nxt = S_ERROR;
          else if (full_word == 32'd0)      state_nxt = S_CSUM;
          else                              state_nxt = S_DATA;
        end else if (timeout_hit) begin
          state_nxt = S_ERROR;
        end
      end
      S_DATA: begin
        // Stay in DATA through the write cycle of the last word so imem_we never leaks out.
        if (imem_we_q && ((word_idx + WIW'(1)) == len_q)) state_nxt = S_CSUM;
        else if (timeout_hit)                             state_nxt = S_ERROR;
      end
      S_CSUM: begin
        if (last_byte)        state_nxt = (full_word == sum_q) ? S_DONE : S_ERROR;
        else if (timeout_hit) state_nxt = S_ERROR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are a pure function of the state.
  always_comb begin
    byte_ready  = 1'b0;
    loader_done = 1'b0;
    load_error  = 1'b0;
    core_rst_n  = 1'b0;
    case (state)
      S_LEN, S_DATA, S_CSUM: byte_ready = 1'b1;
      S_DONE: begin
        loader_done = 1'b1;
        core_rst_n  = 1'b1;
      end
      S_ERROR: load_error = 1'b1;
      default: ;
    endcase
  end

  // Byte assembly, word writes, running sum and idle timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx     <= 2'd0;
      asm_q        <= 24'd0;
      word_idx     <= '0;
      len_q        <= '0;
      sum_q        <= 32'd0;
      idle_cnt     <= 32'd0;
      words_loaded <= 16'd0;
      imem_we_q    <= 1'b0;
      imem_wdata_q <= 32'd0;
    end else begin
      imem_we_q <= 1'b0;
      if (start_ok) begin
        byte_idx     <= 2'd0;
        word_idx     <= '0;
        sum_q        <= 32'd0;
        idle_cnt     <= 32'd0;
        words_loaded <= 16'd0;
      end else begin
        if (hs) begin
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0:    asm_q[7:0]   <= byte_data;
            2'd1:    asm_q[15:8]  <= byte_data;
            2'd2:    asm_q[23:16] <= byte_data;
            default: ;
          endcase
        end
        if ((state == S_LEN) && last_byte) begin
          len_q <= full_word[WIW-1:0];
        end
        if ((state == S_DATA) && last_byte) begin
          imem_we_q    <= 1'b1;
          imem_wdata_q <= full_word;
        end
        if (imem_we_q) begin
          sum_q        <= sum_q + imem_wdata_q;
          words_loaded <= words_loaded + 16'd1;
          word_idx     <= word_idx + WIW'(1);
        end
        if (hs || (state_nxt != state)) begin
          idle_cnt <= 32'd0;
        end else if (active) begin
          idle_cnt <= idle_cnt + 32'd1;
        end
        // A partial word never survives into ERROR.
        if (state_nxt == S_ERROR) begin
          byte_idx <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_load;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        loader_done;
  logic        load_error;
  logic        core_rst_n;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  logic [7:0] normal_img [16] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                  8'h13, 8'h00, 8'h00, 8'h00,
                                  8'h93, 8'h00, 8'h50, 8'h00,
                                  8'hA6, 8'h00, 8'h50, 8'h00};
  logic [7:0] bad_img [16]    = '{8'h02, 8'h00, 8'h00, 8'h00,
                                  8'h13, 8'h00, 8'h00, 8'h00,
                                  8'h93, 8'h00, 8'h50, 8'h00,
                                  8'hA6, 8'h00, 8'h50, 8'h01};

  imem_boot_loader #(
    .IMEM_WORDS     (1024),
    .BASE_ADDR      (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_load   (start_load),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .loader_done  (loader_done),
    .load_error   (load_error),
    .core_rst_n   (core_rst_n),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 64; i++) begin
      ok = byte_ready;
      @(posedge clk);
      @(negedge clk);
      if (ok) break;
    end
    if (!ok) check("byte_accept", 32'd0, 32'd1);
  endtask

  task automatic send_image(input logic [7:0] img [16], input bit throttle);
    for (int i = 0; i < 16; i++) begin
      send_byte(img[i]);
      if (throttle && i != 15) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_load = 1'b0;
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_normal_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_addr0"}, wr_addr[0], 32'h0000_0000);
      check({tag, "_data0"}, wr_data[0], 32'h0000_0013);
      check({tag, "_addr1"}, wr_addr[1], 32'h0000_0004);
      check({tag, "_data1"}, wr_data[1], 32'h0050_0093);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"},   32'(byte_ready),   32'd0);
    check({tag, "_imem_we"},      32'(imem_we),      32'd0);
    check({tag, "_imem_waddr"},   imem_waddr,        32'h0000_0000);
    check({tag, "_imem_wdata"},   imem_wdata,        32'h0000_0000);
    check({tag, "_loader_done"},  32'(loader_done),  32'd0);
    check({tag, "_load_error"},   32'(load_error),   32'd0);
    check({tag, "_core_rst_n"},   32'(core_rst_n),   32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000ns");
    $fatal(1, "bench stalled");
  end

  initial begin
    rst        = 1'b1;
    start_load = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_byte_ready", 32'(byte_ready), 32'd0);

    // Normal two-word load, back-to-back bytes.
    clear_writes();
    pulse_start();
    check("normal_ready_after_start", 32'(byte_ready), 32'd1);
    send_image(normal_img, 1'b0);
    check("normal_done", 32'(loader_done), 32'd1);
    check("normal_core_rst_n", 32'(core_rst_n), 32'd1);
    check("normal_error", 32'(load_error), 32'd0);
    check("normal_words", 32'(words_loaded), 32'd2);
    check("normal_ready_in_done", 32'(byte_ready), 32'd0);
    check_normal_writes("normal");

    // Zero length image, restarted from DONE.
    clear_writes();
    pulse_start();
    check("zero_done_cleared", 32'(loader_done), 32'd0);
    check("zero_core_rst_n_low", 32'(core_rst_n), 32'd0);
    check("zero_words_cleared", 32'(words_loaded), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'h00);
    byte_valid = 1'b0;
    check("zero_done", 32'(loader_done), 32'd1);
    check("zero_words", 32'(words_loaded), 32'd0);
    check("zero_nwr", 32'(wr_addr.size()), 32'd0);

    // Oversize length N=1025.
    clear_writes();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h00);
    byte_valid = 1'b0;
    check("oversize_error", 32'(load_error), 32'd1);
    check("oversize_core_rst_n", 32'(core_rst_n), 32'd0);
    repeat (3) @(negedge clk);
    check("oversize_nwr", 32'(wr_addr.size()), 32'd0);
    check("oversize_words", 32'(words_loaded), 32'd0);

    // Bad checksum, restarted from ERROR.
    clear_writes();
    pulse_start();
    check("badcsum_error_cleared", 32'(load_error), 32'd0);
    send_image(bad_img, 1'b0);
    check("badcsum_error", 32'(load_error), 32'd1);
    check("badcsum_done", 32'(loader_done), 32'd0);
    check("badcsum_core_rst_n", 32'(core_rst_n), 32'd0);
    check_normal_writes("badcsum");

    // Timeout: 6 bytes then silence; ERROR 16 cycles after the last handshake.
    clear_writes();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(normal_img[i]);
    byte_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("timeout_not_yet", 32'(load_error), 32'd0);
    @(negedge clk);
    check("timeout_error", 32'(load_error), 32'd1);
    check("timeout_nwr", 32'(wr_addr.size()), 32'd0);

    // Restart from ERROR with byte_valid toggling every other cycle.
    clear_writes();
    pulse_start();
    check("restart_error_cleared", 32'(load_error), 32'd0);
    check("restart_ready", 32'(byte_ready), 32'd1);
    send_image(normal_img, 1'b1);
    check("restart_done", 32'(loader_done), 32'd1);
    check("restart_core_rst_n", 32'(core_rst_n), 32'd1);
    check("restart_words", 32'(words_loaded), 32'd2);
    check_normal_writes("restart");

    // Reset right after the first word write.
    clear_writes();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(normal_img[i]);
    check("midreset_first_we", 32'(imem_we), 32'd1);
    check("midreset_first_data", imem_wdata, 32'h0000_0013);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b0;
    check_reset_outputs("midreset");
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) @(negedge clk);
    check("midreset_idle_no_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
